// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, funct codes, ALU encodings, mux selects
// and the multicycle controller state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  // States that hold a memory request until mem_ready or timeout.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory:
// instruction fields and status in, mux selects, enables and handshake out.
interface mc_controller_if;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic       buserr;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, buserr
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, buserr
  );

endinterface

// File: rtl/aludec.sv
// R-type ALU decoder: maps funct to an ALU operation and flags funct codes
// the datapath does not implement.
module aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    valid      = 1'b1;
    alucontrol = ALU_ADD;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared ALU/memory
// datapath, with a bounded wait on every memory access.
module mc_controller
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    funct_alu;
  logic          funct_valid;
  logic          op_legal;
  logic          waiting;
  logic          timeout;
  logic          pcwrite;
  logic          branch;

  aludec u_aludec (
    .funct      (bus.funct),
    .alucontrol (funct_alu),
    .valid      (funct_valid)
  );

  always_comb begin
    case (bus.op)
      OP_RTYPE:                         op_legal = funct_valid;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  end

  // A wait cycle is one spent in a memory state without mem_ready; the
  // TIMEOUT-th such cycle aborts, unless mem_ready arrives in it.
  assign waiting = is_wait_state(state) && !bus.mem_ready;
  assign timeout = (TIMEOUT != 0) && waiting && (wait_cnt == CNT_LAST);

  // NOTE: state and counter use <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      if (waiting && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                     wait_cnt <= '0;

      if (timeout) begin
        state <= S_FETCH;
      end else begin
        case (state)
          S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
          S_DECODE: begin
            case (bus.op)
              OP_LW, OP_SW: state <= S_MEMADR;
              OP_RTYPE:     state <= funct_valid ? S_EXECUTE : S_FETCH;
              OP_BEQ:       state <= S_BRANCH;
              OP_ADDI:      state <= S_ADDIEX;
              OP_J:         state <= S_JUMP;
              default:      state <= S_FETCH;
            endcase
          end
          S_MEMADR: begin
            if      (bus.op == OP_LW) state <= S_MEMRD;
            else if (bus.op == OP_SW) state <= S_MEMWR;
            else                      state <= S_FETCH;
          end
          S_MEMRD:   if (bus.mem_ready) state <= S_MEMWB;
          S_MEMWR:   if (bus.mem_ready) state <= S_FETCH;
          S_EXECUTE: state <= S_ALUWB;
          S_ADDIEX:  state <= S_ADDIWB;
          default:   state <= S_FETCH;
        endcase
      end
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = SRCB_RT;
    bus.pcsrc      = PC_ALU;
    bus.alucontrol = ALU_ADD;
    bus.illegal    = 1'b0;
    pcwrite        = 1'b0;
    branch         = 1'b0;

    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          pcwrite     = 1'b1;
          bus.alusrcb = SRCB_FOUR;
        end
      end
      S_DECODE: begin
        bus.alusrcb = SRCB_IMMSH;
        bus.illegal = !op_legal;
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
      end
      S_EXECUTE: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = funct_alu;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = PC_ALUOUT;
        branch         = 1'b1;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: bus.regwrite = 1'b1;
      S_JUMP: begin
        bus.pcsrc = PC_JUMP;
        pcwrite   = 1'b1;
      end
      default: ;
    endcase

    bus.buserr = timeout;
    bus.pcen   = pcwrite | (branch & bus.zero);

    // Side-effecting strobes are masked while reset is held, whatever state
    // the flops happen to hold before the first reset edge.
    if (!reset) begin
      bus.mem_req  = 1'b0;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.pcen     = 1'b0;
      bus.regwrite = 1'b0;
      bus.illegal  = 1'b0;
      bus.buserr   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: builds the expected per-cycle control trace of
// each instruction from its step list and compares the DUT cycle by cycle.
module tb_mc_controller;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mc_controller_if bus ();

  mc_controller #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic       buserr;
  } ctrl_t;

  typedef struct {
    ctrl_t exp;
    bit    rdy;
    bit    zero;
    string name;
  } step_t;

  step_t plan[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctrl_t idle();
    ctrl_t c = '0;
    c.alucontrol = 3'b010;
    return c;
  endfunction

  function automatic ctrl_t observed();
    ctrl_t c;
    c.mem_req    = bus.mem_req;
    c.memwrite   = bus.memwrite;
    c.iord       = bus.iord;
    c.irwrite    = bus.irwrite;
    c.pcen       = bus.pcen;
    c.regwrite   = bus.regwrite;
    c.regdst     = bus.regdst;
    c.memtoreg   = bus.memtoreg;
    c.alusrca    = bus.alusrca;
    c.alusrcb    = bus.alusrcb;
    c.pcsrc      = bus.pcsrc;
    c.alucontrol = bus.alucontrol;
    c.illegal    = bus.illegal;
    c.buserr     = bus.buserr;
    return c;
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] funct);
    if (op == 6'b000000)
      return funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    return op inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] funct);
    case (funct)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic void push(input ctrl_t c, input bit rdy, input bit z, input string name);
    step_t s;
    s.exp  = c;
    s.rdy  = rdy;
    s.zero = z;
    s.name = name;
    plan.push_back(s);
  endfunction

  // w cycles with mem_ready low, then one with it high; w >= TO never completes.
  function automatic bit mem_phase(input ctrl_t base, input ctrl_t done, input int w,
                                   input string name);
    bit to = (w >= TO);
    int n  = to ? TO : w;
    for (int i = 0; i < n; i++) begin
      ctrl_t c = base;
      if (to && i == TO - 1) c.buserr = 1'b1;
      push(c, 1'b0, rbit(), name);
    end
    if (!to) push(done, 1'b1, rbit(), name);
    return to;
  endfunction

  function automatic void plan_instr(input logic [5:0] op, input logic [5:0] funct,
                                     input bit zbr, input int fw, input int mw);
    ctrl_t c, d;
    c = idle(); c.mem_req = 1'b1;
    d = c; d.irwrite = 1'b1; d.pcen = 1'b1; d.alusrcb = 2'b01;
    if (mem_phase(c, d, fw, "fetch")) void'(mem_phase(c, d, 0, "refetch"));

    c = idle(); c.alusrcb = 2'b11;
    c.illegal = !legal(op, funct);
    push(c, rbit(), rbit(), "decode");
    if (c.illegal) return;

    case (op)
      6'b100011, 6'b101011: begin
        c = idle(); c.alusrca = 1'b1; c.alusrcb = 2'b10;
        push(c, rbit(), rbit(), "memadr");
        c = idle(); c.mem_req = 1'b1; c.iord = 1'b1;
        if (op == 6'b101011) begin
          c.memwrite = 1'b1;
          void'(mem_phase(c, c, mw, "memwr"));
        end else if (!mem_phase(c, c, mw, "memrd")) begin
          c = idle(); c.regwrite = 1'b1; c.memtoreg = 1'b1;
          push(c, rbit(), rbit(), "memwb");
        end
      end
      6'b000000: begin
        c = idle(); c.alusrca = 1'b1; c.alucontrol = alu_of(funct);
        push(c, rbit(), rbit(), "execute");
        c = idle(); c.regwrite = 1'b1; c.regdst = 1'b1;
        push(c, rbit(), rbit(), "aluwb");
      end
      6'b000100: begin
        c = idle(); c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
        c.pcen = zbr;
        push(c, rbit(), zbr, "branch");
      end
      6'b001000: begin
        c = idle(); c.alusrca = 1'b1; c.alusrcb = 2'b10;
        push(c, rbit(), rbit(), "addiex");
        c = idle(); c.regwrite = 1'b1;
        push(c, rbit(), rbit(), "addiwb");
      end
      default: begin
        c = idle(); c.pcsrc = 2'b10; c.pcen = 1'b1;
        push(c, rbit(), rbit(), "jump");
      end
    endcase
  endfunction

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                           input bit zbr, input int fw, input int mw);
    plan.delete();
    plan_instr(op, funct, zbr, fw, mw);
    bus.op    = op;
    bus.funct = funct;
    foreach (plan[i]) begin
      bus.mem_ready = plan[i].rdy;
      bus.zero      = plan[i].zero;
      @(negedge clk);
      check($sformatf("%s op=%b fn=%b c%0d", plan[i].name, op, funct, i + 1),
            32'(observed()), 32'(plan[i].exp));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 9) == 0) return $urandom_range(TO - 2, TO + 1);
    return $urandom_range(0, 3);
  endfunction

  initial begin
    bus.op        = 6'b000000;
    bus.funct     = 6'b100000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    reset         = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("reset_strobes",
            32'({bus.mem_req, bus.memwrite, bus.irwrite, bus.pcen, bus.regwrite}), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b1;

    run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);        // lw, zero wait
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);        // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);        // beq not taken
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 4);        // sw, 4 wait cycles
    run_instr(6'b100011, 6'b000000, 1'b0, 0, TO);       // lw, memory never answers
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);        // unknown op
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);        // unknown funct
    run_instr(6'b100011, 6'b000000, 1'b0, 0, TO - 1);   // ready in the last allowed cycle
    run_instr(6'b001000, 6'b000000, 1'b0, TO + 2, 0);   // fetch timeout then retry
    run_instr(6'b000000, 6'b101010, 1'b0, 2, 0);        // slt
    run_instr(6'b000010, 6'b000000, 1'b0, 1, 0);        // j

    for (int n = 0; n < 250; n++) begin
      logic [5:0] op, funct;
      funct = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin
          op = 6'b000000;
          case ($urandom_range(0, 5))
            0: funct = 6'b100000;
            1: funct = 6'b100010;
            2: funct = 6'b100100;
            3: funct = 6'b100101;
            4: funct = 6'b101010;
            default: ;
          endcase
        end
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        6: op = 6'b000000;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, funct, rbit(), rand_wait(), rand_wait());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS core. Sequences the shared single-ALU/single-memory multicycle datapath one instruction at a time. It decodes the opcode and funct held in the instruction register and drives every mux select, register enable and ALU operation. It also handshakes with the unified instruction/data memory and bounds each memory wait with a timeout.

## Interface
- TIMEOUT, 16, max consecutive cycles spent waiting on mem_ready in one memory state; 0 disables the timeout
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  write strobe, valid with mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register load
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- regwrite  out  1  register file write
- regdst  out  1  write reg: 0 = rt, 1 = rd
- memtoreg  out  1  writeback: 0 = ALUOut, 1 = memory data
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse: unsupported op/funct
- buserr  out  1  one-cycle pulse: memory timeout

## Operation
- Supported instructions: R-type add/sub/and/or/slt, lw, sw, beq, addi, j.
- Moore FSM. Outputs are decoded from the state; mem_ready gates the outputs of the wait states. All outputs not listed for a state are 0; alucontrol defaults to 010.
- FETCH: mem_req=1, iord=0. Waits for mem_ready. In the mem_ready cycle it drives irwrite=1, pcwrite=1, alusrcb=01, pcsrc=00 and moves to DECODE.
- DECODE: alusrcb=11, add, which precomputes the branch target. Next state by op:
  - lw/sw → MEMADR
  - R-type → EXECUTE
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - unknown op, or R-type with unknown funct → FETCH with illegal=1
- MEMADR: alusrca=1, alusrcb=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Moves to MEMWB on mem_ready.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next state FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1, all held until mem_ready. Next state FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct. Next state ALUWB.
- ALUWB: regwrite=1, regdst=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next state ADDIWB.
- ADDIWB: regwrite=1, regdst=0. Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state FETCH.
- Wait counter:
  - Counts cycles in FETCH/MEMRD/MEMWR with mem_ready=0 and clears on any state change.
  - If mem_ready is still 0 in the TIMEOUT-th waiting cycle, buserr=1 that cycle and the next state is FETCH. From FETCH this is a retry; PC is unchanged.
  - Counter width is $clog2(TIMEOUT+1).

## Timing
- reset=0 at an edge loads FETCH and clears the wait counter.
- While reset=0, mem_req, memwrite, irwrite, pcen and regwrite are forced to 0 combinationally.
- First fetch request is visible in the cycle after reset rises.
- Latency with zero-wait memory (mem_ready=1 in the first cycle), in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each memory wait cycle adds one cycle.
- mem_ready is sampled only in FETCH/MEMRD/MEMWR and ignored elsewhere.
- A mem_ready arriving in the timeout cycle wins: normal transition, no buserr.
- The handshake is level-based and the request never drops before mem_ready or timeout. Address and write strobe are stable for the whole wait.
- beq: pcen=zero in the BRANCH cycle only.

## Structure
- Shared package mips_pkg holds:
  - opcode constants: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010
  - funct constants: 100000/100010/100100/100101/101010
  - alucontrol encodings
  - state enum typedef
- Sub-module aludec (combinational funct → alucontrol, plus a valid flag); its valid flag feeds the DECODE illegal check.

## Test plan
- Reset held low 3 cycles with mem_ready=1 → mem_req=pcen=regwrite=0 throughout; after release FETCH is asserted with iord=0.
- lw (op 100011), mem_ready always 1 → state sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 with memtoreg=1 in cycle 5.
- beq with zero=1, then with zero=0 → pcen=1 and pcsrc=01 in cycle 3 for the first; pcen=0 in cycle 3 for the second.
- sw with mem_ready low 4 cycles in MEMWR → memwrite/iord held 4 cycles; FETCH follows the mem_ready cycle; buserr=0.
- TIMEOUT=16, mem_ready never asserted in MEMRD → buserr pulse in the 16th wait cycle, then FETCH; no regwrite occurs.
- op 111111, then R-type funct 000000 → illegal pulse in DECODE, return to FETCH; no regwrite or memwrite.
